ks_prefix_sum_16b: RTL and testbench

Pipelined downstream stage of the 16-bit Kogge-Stone adder. It consumes the bitwise propagate, generate and carry-in bundle from the PG stage, and runs the four prefix levels at distances 1, 2, 4 and 8. It then forms the sum and carry-out. Output registers sit behind a valid/ready handshake with a global stall, so the adder can be used in FFT butterfly datapaths that apply backpressure.

---
 rtl/ks_pkg.sv | 19 +
 rtl/ks_black_cell.sv | 14 +
 rtl/ks_prefix_sum_16b.sv | 150 +++++++++++++++
 tb/tb_ks_prefix_sum_16b.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the 16-bit Kogge-Stone prefix/sum stage.
package ks_pkg;

  localparam int unsigned KS_W      = 16;
  localparam int unsigned KS_LEVELS = 4;

  typedef struct packed {
    logic [KS_W-1:0] p;
    logic [KS_W-1:0] g;
    logic [KS_W-1:0] porig;
    logic            c0;
    logic            vld;
  } ks_pg_t;

  function automatic int unsigned ks_dist(input int unsigned k);
    return 32'd1 << (k - 32'd1);
  endfunction

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone black cell: merges a high group (Gh, Ph) with a lower group (Gl, Pl).
module ks_black_cell (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;

endmodule

// File: rtl/ks_prefix_sum_16b.sv
// Kogge-Stone prefix levels (distances 1, 2, 4, 8) and registered sum stage behind a global stall.
// Optional overflow output o_ovf is enabled by defining KS_OVF_EN.
module ks_prefix_sum_16b
  import ks_pkg::*;
#(
  parameter logic [KS_LEVELS-1:0] PIPE_MASK = 4'b1111
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [KS_W-1:0] i_pk_1,
  input  logic [KS_W-1:0] i_gk_1,
  input  logic            i_c0_1,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [KS_W-1:0] o_sum,
  output logic            o_cout
`ifdef KS_OVF_EN
  ,
  output logic            o_ovf
`endif
);

  logic valid_q, valid_d;
  logic [KS_W-1:0] sum_q, sum_d;
  logic cout_q, cout_d;
  logic advance;

  // Combinational ready path: every register in the pipe shares this enable.
  assign advance = !valid_q || i_ready;
  assign o_ready = advance;

  ks_pg_t stg0;

  always_comb begin
    stg0.p     = i_pk_1;
    stg0.g     = i_gk_1;
    stg0.g[0]  = i_gk_1[0] | (i_pk_1[0] & i_c0_1);
    stg0.porig = i_pk_1;
    stg0.c0    = i_c0_1;
    stg0.vld   = i_valid;
  end

  for (genvar k = 1; k <= KS_LEVELS; k++) begin : g_lvl
    localparam int unsigned D = ks_dist(k);

    ks_pg_t lvl_in, lvl_comb, lvl_out;
    logic [KS_W-1:0] g_n, p_n;

    if (k == 1) begin : g_first
      assign lvl_in = stg0;
    end else begin : g_chain
      assign lvl_in = g_lvl[k-1].lvl_out;
    end

    for (genvar i = 0; i < KS_W; i++) begin : g_bit
      if (i >= D) begin : g_cell
        ks_black_cell u_cell (
          .gh_i(lvl_in.g[i]),
          .ph_i(lvl_in.p[i]),
          .gl_i(lvl_in.g[i-D]),
          .pl_i(lvl_in.p[i-D]),
          .g_o (g_n[i]),
          .p_o (p_n[i])
        );
      end else begin : g_pass
        assign g_n[i] = lvl_in.g[i];
        assign p_n[i] = lvl_in.p[i];
      end
    end

    always_comb begin
      lvl_comb   = lvl_in;
      lvl_comb.g = g_n;
      lvl_comb.p = p_n;
    end

    if (PIPE_MASK[k-1]) begin : g_reg
      ks_pg_t lvl_d, lvl_q;

      always_comb lvl_d = advance ? lvl_comb : lvl_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) lvl_q <= '0;
        else       lvl_q <= lvl_d;
      end

      assign lvl_out = lvl_q;
    end else begin : g_comb
      assign lvl_out = lvl_comb;
    end
  end

  ks_pg_t fin;
  logic [KS_W-1:0] carry;
  logic unused_fin_p;

  assign fin   = g_lvl[KS_LEVELS].lvl_out;
  assign carry = {fin.g[KS_W-2:0], fin.c0};
  // Group propagate after the last level has no consumer.
  assign unused_fin_p = ^fin.p;

`ifdef KS_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef KS_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (advance) begin
      valid_d = fin.vld;
      sum_d   = fin.porig ^ carry;
      cout_d  = fin.g[KS_W-1];
`ifdef KS_OVF_EN
      ovf_d   = carry[KS_W-1] ^ fin.g[KS_W-1];
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef KS_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef KS_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
`ifdef KS_OVF_EN
  assign o_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_ks_prefix_sum_16b.sv
// Directed bench for ks_prefix_sum_16b: three instances with PIPE_MASK 1111, 0101 and 0000.
module tb_ks_prefix_sum_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] pk, gk;
  logic        c0;

  logic [2:0]  ovld, ordy, ocout;
  logic [15:0] osum [3];
`ifdef KS_OVF_EN
  logic [2:0]  oovf;
`endif

  int lat [3] = '{5, 3, 1};
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ks_prefix_sum_16b #(.PIPE_MASK(4'b1111)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[0]),
    .i_pk_1(pk), .i_gk_1(gk), .i_c0_1(c0), .o_valid(ovld[0]), .i_ready(i_ready),
    .o_sum(osum[0]), .o_cout(ocout[0])
`ifdef KS_OVF_EN
    , .o_ovf(oovf[0])
`endif
  );

  ks_prefix_sum_16b #(.PIPE_MASK(4'b0101)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[1]),
    .i_pk_1(pk), .i_gk_1(gk), .i_c0_1(c0), .o_valid(ovld[1]), .i_ready(i_ready),
    .o_sum(osum[1]), .o_cout(ocout[1])
`ifdef KS_OVF_EN
    , .o_ovf(oovf[1])
`endif
  );

  ks_prefix_sum_16b #(.PIPE_MASK(4'b0000)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[2]),
    .i_pk_1(pk), .i_gk_1(gk), .i_c0_1(c0), .o_valid(ovld[2]), .i_ready(i_ready),
    .o_sum(osum[2]), .o_cout(ocout[2])
`ifdef KS_OVF_EN
    , .o_ovf(oovf[2])
`endif
  );

  typedef struct {
    logic [15:0] p;
    logic [15:0] g;
    logic        c0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [10];
  vec_t bp  [8];
  vec_t sw  [1000];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from operands: a = p|g, b = g reproduces the same (p, g) pair.
  function automatic vec_t rand_vec();
    vec_t v;
    logic [15:0] a, b;
    logic [16:0] s;
    a = 16'($urandom);
    b = 16'($urandom);
    v.p  = a ^ b;
    v.g  = a & b;
    v.c0 = 1'($urandom);
    s = {1'b0, a} + {1'b0, b} + {16'b0, v.c0};
    v.sum  = s[15:0];
    v.cout = s[16];
    v.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    return v;
  endfunction

  task automatic chk_out(input string tag, input int d, input vec_t v);
    chk($sformatf("%s sum dut%0d", tag, d), osum[d], v.sum);
    chk($sformatf("%s cout dut%0d", tag, d), ocout[d], v.cout);
`ifdef KS_OVF_EN
    chk($sformatf("%s ovf dut%0d", tag, d), oovf[d], v.ovf);
`endif
  endtask

  // Single transaction; each instance must raise o_valid exactly at its own latency.
  task automatic issue_and_check(input vec_t v, input string tag);
    pk = v.p; gk = v.g; c0 = v.c0; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s valid dut%0d cyc%0d", tag, d, c), ovld[d], (c == lat[d]));
        if (c == lat[d]) chk_out(tag, d, v);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{16'h7FFE, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[1] = '{16'hFFFE, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h5115, 16'h0220, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h00FE, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; pk = '0; gk = '0; c0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst valid dut%0d", d), ovld[d], 0);
      chk($sformatf("rst sum dut%0d", d), osum[d], 0);
      chk($sformatf("rst cout dut%0d", d), ocout[d], 0);
      chk($sformatf("rst ready dut%0d", d), ordy[d], 1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) issue_and_check(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: 8 back-to-back operands, i_ready low in cycles 3..10.
    for (int i = 0; i < 8; i++) bp[i] = rand_vec();
    fork
      begin : bp_drv
        int  idx = 0;
        bit  acc;
        for (int t = 0; t < 60 && idx < 8; t++) begin
          pk = bp[idx].p; gk = bp[idx].g; c0 = bp[idx].c0; i_valid = 1'b1;
          @(negedge clk) acc = ordy[0];
          @(posedge clk); #1;
          if (acc) idx++;
        end
        i_valid = 1'b0;
      end
      begin : bp_rdy
        for (int cyc = 0; cyc <= 10; cyc++) begin
          i_ready = !(cyc >= 3);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
      begin : bp_mon
        int          got = 0;
        bit          pstall = 1'b0;
        logic [15:0] psum = '0;
        logic        pcout = 1'b0;
        for (int t = 0; t < 80 && got < 8; t++) begin
          @(negedge clk);
          if (pstall) begin
            chk("bp hold valid", ovld[0], 1);
            chk("bp hold sum", osum[0], psum);
            chk("bp hold cout", ocout[0], pcout);
          end
          if (ovld[0] && !i_ready) chk("bp ready low", ordy[0], 0);
          if (ovld[0] && i_ready) begin
            chk_out($sformatf("bp%0d", got), 0, bp[got]);
            got++;
          end
          pstall = ovld[0] && !i_ready;
          psum   = osum[0];
          pcout  = ocout[0];
        end
        chk("bp result count", got, 8);
        for (int t = 0; t < 8; t++) begin
          @(negedge clk);
          chk("bp no duplicate", ovld[0], 0);
        end
      end
    join

    // Reset with three transactions in flight.
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      pk = bp[j].p; gk = bp[j].g; c0 = bp[j].c0; i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst ready during", ordy[0], 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid rst valid", ovld[0], 0);
    chk("mid rst sum", osum[0], 0);
    chk("mid rst cout", ocout[0], 0);
    chk("mid rst ready after", ordy[0], 1);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("mid rst no stale", ovld[0], 0);
    end
    @(posedge clk); #1;
    issue_and_check(tbl[0], "post_rst");

    // Latency sweep: identical results across all three masks for 1000 random vectors.
    for (int i = 0; i < 1000; i++) sw[i] = rand_vec();
    fork
      begin : sw_drv
        for (int i = 0; i < 1000; i++) begin
          pk = sw[i].p; gk = sw[i].g; c0 = sw[i].c0; i_valid = 1'b1;
          @(posedge clk); #1;
        end
        i_valid = 1'b0;
      end
      begin : sw_mon
        int cnt [3] = '{0, 0, 0};
        for (int t = 0; t < 1100 && (cnt[0] < 1000 || cnt[1] < 1000 || cnt[2] < 1000); t++) begin
          @(negedge clk);
          for (int d = 0; d < 3; d++) begin
            if (ovld[d]) begin
              if (cnt[d] < 1000) chk_out($sformatf("sw%0d", cnt[d]), d, sw[cnt[d]]);
              cnt[d]++;
            end
          end
        end
        for (int d = 0; d < 3; d++) chk($sformatf("sw count dut%0d", d), cnt[d], 1000);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
